// File: rtl/led_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// led_ctrl_pkg
// Shared constants and types for the LED command sequencer slice.
//   - Frame geometry: CMD_W-bit frame = {instr[STATE_W-1:0], addr[ADDR_W-1:0]}
//   - Broadcast address that writes every LED at once
//   - Sequencer FSM state encoding
//   - Instruction codes; the sequencer stores them raw, and the per-LED
//     output stage interprets them
// ----------------------------------------------------------------------------
package led_ctrl_pkg;

    localparam int STATE_W  = 3;
    localparam int ADDR_W   = 5;
    localparam int NUM_LEDS = 23;
    localparam int CMD_W    = 8;

    localparam logic [ADDR_W-1:0] BCAST_ADDR = 5'd31;

    // Bit counter saturates here so over-long frames stay distinguishable
    // from exact 8-bit frames without the counter wrapping.
    localparam logic [3:0] BIT_CNT_SAT = 4'd9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } seq_state_e;

    localparam logic [STATE_W-1:0] INSTR_OFF  = 3'd0;
    localparam logic [STATE_W-1:0] INSTR_ON   = 3'd1;
    localparam logic [STATE_W-1:0] INSTR_SLOW = 3'd2;
    localparam logic [STATE_W-1:0] INSTR_FAST = 3'd3;

endpackage

// File: rtl/pattern_gen.sv
// ----------------------------------------------------------------------------
// pattern_gen
// Free-running square-wave generator. The counter runs 0..DIV-1; on reaching
// DIV-1 it wraps to 0 and the output toggles, giving a half-period of DIV
// clock cycles.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset (counter and output cleared)
//   pat   - square wave output
// ----------------------------------------------------------------------------
module pattern_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic pat
);

    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pat_q, pat_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        pat_d = pat_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            pat_d = ~pat_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            pat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pat_q <= pat_d;
        end
    end

    assign pat = pat_q;

endmodule

// File: rtl/led_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// led_cmd_sequencer
// Serial command front-end and LED state table. Frames of CMD_W bits arrive
// MSB first on DATA, clocked by SCK and framed by LATCH. On LATCH fall the
// frame is committed: the instruction field is written into the addressed
// LED's state slot (or into every slot for the broadcast address). Also
// produces the slow and fast blink patterns used by the LED output stages.
// Ports:
//   CLK       - system clock, all logic on rising edge
//   RESET     - asynchronous active-low reset
//   SCK       - serial bit clock (asynchronous, synchronised here)
//   DATA      - serial data, sampled on synchronised SCK rise
//   LATCH     - frame enable; high opens a frame, falling edge commits it
//   LED_STATE - packed state table, LED n at [n*STATE_W +: STATE_W]
//   CMD_VALID - 1-cycle pulse when a frame updates the table
//   FRAME_ERR - 1-cycle pulse when a frame did not carry exactly CMD_W bits
//   ADDR_ERR  - 1-cycle pulse when an 8-bit frame names a nonexistent LED
//   PAT_SLOW  - square wave, half-period SLOW_DIV cycles
//   PAT_FAST  - square wave, half-period FAST_DIV cycles
// ----------------------------------------------------------------------------
module led_cmd_sequencer #(
    parameter int NUM_LEDS = led_ctrl_pkg::NUM_LEDS,
    parameter int ADDR_W   = led_ctrl_pkg::ADDR_W,
    parameter int STATE_W  = led_ctrl_pkg::STATE_W,
    parameter int SLOW_DIV = 1000000,
    parameter int FAST_DIV = 250000
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        SCK,
    input  logic                        DATA,
    input  logic                        LATCH,
    output logic [NUM_LEDS*STATE_W-1:0] LED_STATE,
    output logic                        CMD_VALID,
    output logic                        FRAME_ERR,
    output logic                        ADDR_ERR,
    output logic                        PAT_SLOW,
    output logic                        PAT_FAST
);

    import led_ctrl_pkg::*;

    localparam int FRAME_W = ADDR_W + STATE_W;

    // Two-flop synchronisers plus a one-cycle delayed copy of SCK and LATCH
    // for edge detection. DATA only needs the synchroniser; it is sampled
    // when the equally delayed SCK shows a rising edge.
    logic sck_meta_q, sck_sync_q, sck_prev_q;
    logic data_meta_q, data_sync_q;
    logic latch_meta_q, latch_sync_q, latch_prev_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sck_meta_q   <= 1'b0;
            sck_sync_q   <= 1'b0;
            sck_prev_q   <= 1'b0;
            data_meta_q  <= 1'b0;
            data_sync_q  <= 1'b0;
            latch_meta_q <= 1'b0;
            latch_sync_q <= 1'b0;
            latch_prev_q <= 1'b0;
        end else begin
            sck_meta_q   <= SCK;
            sck_sync_q   <= sck_meta_q;
            sck_prev_q   <= sck_sync_q;
            data_meta_q  <= DATA;
            data_sync_q  <= data_meta_q;
            latch_meta_q <= LATCH;
            latch_sync_q <= latch_meta_q;
            latch_prev_q <= latch_sync_q;
        end
    end

    logic sck_rise, latch_rise, latch_fall;

    assign sck_rise   = sck_sync_q & ~sck_prev_q;
    assign latch_rise = latch_sync_q & ~latch_prev_q;
    assign latch_fall = ~latch_sync_q & latch_prev_q;

    seq_state_e                  state_q, state_d;
    logic [FRAME_W-1:0]          sr_q, sr_d;
    logic [3:0]                  bit_cnt_q, bit_cnt_d;
    logic [NUM_LEDS*STATE_W-1:0] led_state_q, led_state_d;
    logic                        cmd_valid_q, cmd_valid_d;
    logic                        frame_err_q, frame_err_d;
    logic                        addr_err_q, addr_err_d;

    logic [ADDR_W-1:0]  cmd_addr;
    logic [STATE_W-1:0] cmd_instr;
    logic               frame_ok;
    logic               is_bcast;
    logic               addr_in_range;

    assign cmd_addr      = sr_q[ADDR_W-1:0];
    assign cmd_instr     = sr_q[FRAME_W-1 -: STATE_W];
    assign frame_ok      = (bit_cnt_q == 4'(FRAME_W));
    assign is_bcast      = (cmd_addr == ADDR_W'(BCAST_ADDR));
    assign addr_in_range = (int'(cmd_addr) < NUM_LEDS);

    // Sequencer next-state and table update. The commit decision is made
    // while sitting in COMMIT; the table and the status pulses are
    // registered together so the pulse lines up with the visible update.
    // A LATCH fall wins over a coincident SCK rise, so that bit is lost
    // and the commit sees the count as it stood.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        bit_cnt_d   = bit_cnt_q;
        led_state_d = led_state_q;
        cmd_valid_d = 1'b0;
        frame_err_d = 1'b0;
        addr_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (latch_rise) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                end
            end

            SHIFT: begin
                if (latch_fall) begin
                    state_d = COMMIT;
                end else if (sck_rise) begin
                    sr_d = {sr_q[FRAME_W-2:0], data_sync_q};
                    if (bit_cnt_q != BIT_CNT_SAT) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end

            COMMIT: begin
                if (!frame_ok) begin
                    frame_err_d = 1'b1;
                end else if (is_bcast || addr_in_range) begin
                    cmd_valid_d = 1'b1;
                    for (int i = 0; i < NUM_LEDS; i++) begin
                        if (is_bcast || (int'(cmd_addr) == i)) begin
                            led_state_d[i*STATE_W +: STATE_W] = cmd_instr;
                        end
                    end
                end else begin
                    addr_err_d = 1'b1;
                end

                if (latch_rise) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state, frame capture and the LED state table.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            led_state_q <= '0;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            led_state_q <= led_state_d;
            cmd_valid_q <= cmd_valid_d;
            frame_err_q <= frame_err_d;
            addr_err_q  <= addr_err_d;
        end
    end

    assign LED_STATE = led_state_q;
    assign CMD_VALID = cmd_valid_q;
    assign FRAME_ERR = frame_err_q;
    assign ADDR_ERR  = addr_err_q;

    pattern_gen #(
        .DIV (SLOW_DIV)
    ) u_pat_slow (
        .clk   (CLK),
        .rst_n (RESET),
        .pat   (PAT_SLOW)
    );

    pattern_gen #(
        .DIV (FAST_DIV)
    ) u_pat_fast (
        .clk   (CLK),
        .rst_n (RESET),
        .pat   (PAT_FAST)
    );

endmodule

// File: tb/tb_led_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// tb_led_cmd_sequencer
// Self-checking bench for led_cmd_sequencer with short blink dividers.
// A reference model holds one state value per LED and applies the commit
// rules directly to each frame the bench sends.
// ----------------------------------------------------------------------------
module tb_led_cmd_sequencer;

    localparam int NUM_LEDS = 23;
    localparam int STATE_W  = 3;
    localparam int SLOW_DIV = 6;
    localparam int FAST_DIV = 2;
    localparam int PHASE    = 4;

    logic                        CLK;
    logic                        RESET;
    logic                        SCK;
    logic                        DATA;
    logic                        LATCH;
    logic [NUM_LEDS*STATE_W-1:0] LED_STATE;
    logic                        CMD_VALID;
    logic                        FRAME_ERR;
    logic                        ADDR_ERR;
    logic                        PAT_SLOW;
    logic                        PAT_FAST;

    int total;
    int bad;

    int model_led[NUM_LEDS];

    led_cmd_sequencer #(
        .NUM_LEDS (NUM_LEDS),
        .ADDR_W   (5),
        .STATE_W  (STATE_W),
        .SLOW_DIV (SLOW_DIV),
        .FAST_DIV (FAST_DIV)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .SCK       (SCK),
        .DATA      (DATA),
        .LATCH     (LATCH),
        .LED_STATE (LED_STATE),
        .CMD_VALID (CMD_VALID),
        .FRAME_ERR (FRAME_ERR),
        .ADDR_ERR  (ADDR_ERR),
        .PAT_SLOW  (PAT_SLOW),
        .PAT_FAST  (PAT_FAST)
    );

    // 10 time-unit system clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [NUM_LEDS*STATE_W-1:0] model_table();
        logic [NUM_LEDS*STATE_W-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            v[i*STATE_W +: STATE_W] = 3'(model_led[i]);
        end
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NUM_LEDS; i++) begin
            model_led[i] = 0;
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Sends nbits of 'bits' MSB first inside one LATCH window, then drops
    // LATCH and checks the outputs before, on and after the commit edge.
    task automatic run_frame(input logic [15:0] bits, input int nbits,
                             input string name);
        logic [NUM_LEDS*STATE_W-1:0] old_tbl;
        logic [NUM_LEDS*STATE_W-1:0] new_tbl;
        logic [2:0] exp_pulse;
        logic [2:0] got_pulse;
        int addr;
        int instr;

        old_tbl = model_table();
        if (nbits != 8) begin
            exp_pulse = 3'b010;
        end else begin
            addr  = int'(bits[4:0]);
            instr = int'(bits[7:5]);
            if (addr == 31) begin
                for (int i = 0; i < NUM_LEDS; i++) model_led[i] = instr;
                exp_pulse = 3'b100;
            end else if (addr < NUM_LEDS) begin
                model_led[addr] = instr;
                exp_pulse = 3'b100;
            end else begin
                exp_pulse = 3'b001;
            end
        end
        new_tbl = model_table();

        LATCH = 1'b1;
        wait_neg(PHASE);
        for (int k = nbits - 1; k >= 0; k--) begin
            DATA = bits[k];
            wait_neg(PHASE);
            SCK = 1'b1;
            wait_neg(PHASE);
            SCK = 1'b0;
        end
        wait_neg(PHASE);
        LATCH = 1'b0;

        repeat (3) @(posedge CLK);
        #1;
        got_pulse = {CMD_VALID, FRAME_ERR, ADDR_ERR};
        total++;
        if (got_pulse !== 3'b000) begin
            bad++;
            $display("[TB] FAIL %s early_pulse got=%b want=000", name, got_pulse);
        end
        total++;
        if (LED_STATE !== old_tbl) begin
            bad++;
            $display("[TB] FAIL %s early_table got=%h want=%h", name, LED_STATE, old_tbl);
        end

        @(posedge CLK);
        #1;
        got_pulse = {CMD_VALID, FRAME_ERR, ADDR_ERR};
        total++;
        if (got_pulse !== exp_pulse) begin
            bad++;
            $display("[TB] FAIL %s pulse got=%b want=%b", name, got_pulse, exp_pulse);
        end
        total++;
        if (LED_STATE !== new_tbl) begin
            bad++;
            $display("[TB] FAIL %s table got=%h want=%h", name, LED_STATE, new_tbl);
        end

        @(posedge CLK);
        #1;
        got_pulse = {CMD_VALID, FRAME_ERR, ADDR_ERR};
        total++;
        if (got_pulse !== 3'b000) begin
            bad++;
            $display("[TB] FAIL %s pulse_width got=%b want=000", name, got_pulse);
        end
        @(negedge CLK);
    endtask

    // Holds reset, checks every output is cleared, then releases on a
    // falling edge so the next rising edge is cycle 1 of the patterns.
    task automatic test_reset();
        SCK   = 1'b0;
        DATA  = 1'b0;
        LATCH = 1'b0;
        RESET = 1'b0;
        model_clear();
        #23;
        @(negedge CLK);
        total++;
        if ({LED_STATE, CMD_VALID, FRAME_ERR, ADDR_ERR, PAT_SLOW, PAT_FAST} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs got=%h/%b%b%b%b%b want=0",
                     LED_STATE, CMD_VALID, FRAME_ERR, ADDR_ERR, PAT_SLOW, PAT_FAST);
        end
        RESET = 1'b1;
    endtask

    task automatic test_patterns();
        logic exp_fast;
        logic exp_slow;
        for (int k = 1; k <= 30; k++) begin
            @(posedge CLK);
            #1;
            exp_fast = ((k / FAST_DIV) % 2) == 1;
            exp_slow = ((k / SLOW_DIV) % 2) == 1;
            total++;
            if (PAT_FAST !== exp_fast) begin
                bad++;
                $display("[TB] FAIL pat_fast cycle=%0d got=%b want=%b", k, PAT_FAST, exp_fast);
            end
            total++;
            if (PAT_SLOW !== exp_slow) begin
                bad++;
                $display("[TB] FAIL pat_slow cycle=%0d got=%b want=%b", k, PAT_SLOW, exp_slow);
            end
        end
        @(negedge CLK);
    endtask

    task automatic test_single_write();
        run_frame(16'b101_00011, 8, "single_write");
        total++;
        if (LED_STATE[11:9] !== 3'b101) begin
            bad++;
            $display("[TB] FAIL led3_field got=%b want=101", LED_STATE[11:9]);
        end
    endtask

    task automatic test_broadcast();
        run_frame(16'b010_11111, 8, "broadcast");
    endtask

    task automatic test_addr_err();
        run_frame(16'b111_11001, 8, "addr_25");
        run_frame(16'b001_10111, 8, "addr_23");
        run_frame(16'b100_10110, 8, "addr_22");
        run_frame(16'b110_00000, 8, "addr_0");
    endtask

    task automatic test_frame_len();
        run_frame(16'b011_0001, 7, "short_frame");
        run_frame(16'b1_011_00010, 9, "long_frame");
    endtask

    // SCK activity while no frame is open must not count as data bits.
    task automatic test_idle_sck();
        for (int k = 0; k < 3; k++) begin
            DATA = 1'b1;
            wait_neg(PHASE);
            SCK = 1'b1;
            wait_neg(PHASE);
            SCK = 1'b0;
        end
        wait_neg(PHASE);
        run_frame(16'b001_00101, 8, "after_idle_sck");
    endtask

    task automatic test_mid_frame_reset();
        logic [3:0] part;
        part = 4'b0010;
        LATCH = 1'b1;
        wait_neg(PHASE);
        for (int k = 3; k >= 0; k--) begin
            DATA = part[k];
            wait_neg(PHASE);
            SCK = 1'b1;
            wait_neg(PHASE);
            SCK = 1'b0;
        end
        RESET = 1'b0;
        #1;
        total++;
        if ({LED_STATE, CMD_VALID, FRAME_ERR, ADDR_ERR} !== '0) begin
            bad++;
            $display("[TB] FAIL async_reset got=%h want=0", LED_STATE);
        end
        LATCH = 1'b0;
        DATA  = 1'b0;
        model_clear();
        wait_neg(3);
        RESET = 1'b1;
        wait_neg(PHASE);
        run_frame(16'b011_00001, 8, "post_reset_frame");
        total++;
        if (LED_STATE[5:0] !== 6'b011_000) begin
            bad++;
            $display("[TB] FAIL led1_led0 got=%b want=011000", LED_STATE[5:0]);
        end
    endtask

    task automatic test_random();
        logic [15:0] bits;
        int          nbits;
        int          sel;
        for (int n = 0; n < 40; n++) begin
            sel  = $urandom_range(0, 9);
            bits = 16'($urandom);
            if (sel == 0) begin
                nbits = 7;
            end else if (sel == 1) begin
                nbits = 9;
            end else begin
                nbits = 8;
                if (sel == 2) bits[4:0] = 5'd31;
                else if (sel < 7) bits[4:0] = 5'($urandom_range(0, NUM_LEDS - 1));
            end
            run_frame(bits, nbits, "random");
        end
    endtask

    task automatic test_back_to_back();
        run_frame(16'b110_00100, 8, "repeat_a");
        run_frame(16'b110_00100, 8, "repeat_b");
        run_frame(16'b000_00100, 8, "overwrite");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_patterns();
        test_single_write();
        test_broadcast();
        test_addr_err();
        test_frame_len();
        test_idle_sck();
        test_back_to_back();
        test_mid_frame_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
